// File: rtl/jam_pkg.sv
// rtl/jam_pkg.sv - shared state encoding and parameter-range helpers for the job-assignment solver
package jam_pkg;

   typedef enum logic [2:0] {IDLE, INIT, EVAL, CMP, STEP, DONE} state_t;

   localparam int MIN_N = 2;
   localparam int MAX_N = 8;

   function automatic longint fact(input int n);
      longint f;
      f = 1;
      for (int i = 2; i <= n; i++) f = f * longint'(i);
      return f;
   endfunction

   // Bits needed to represent v as an unsigned value, never less than 1.
   function automatic int bits_for(input longint v);
      int b;
      b = 1;
      for (int i = 1; i < 63; i++) begin
         if ((longint'(1) << i) <= v) b = i + 1;
      end
      return b;
   endfunction

endpackage

// File: rtl/jam_perm_solver_if.sv
// rtl/jam_perm_solver_if.sv - host-facing handshake, cost ROM and result readout bundle
interface jam_perm_solver_if #(
   parameter int IW  = 3,
   parameter int CW  = 7,
   parameter int SW  = 10,
   parameter int MCW = 16
);
   logic           START;
   logic [IW-1:0]  W;
   logic [IW-1:0]  J;
   logic [CW-1:0]  Cost;
   logic [SW-1:0]  MinCost;
   logic [MCW-1:0] MatchCount;
   logic           Valid;
   logic [IW-1:0]  RD_W;
   logic [IW-1:0]  RD_J;

   modport master (output START, Cost, RD_W,
                   input  W, J, MinCost, MatchCount, Valid, RD_J);
   modport slave  (input  START, Cost, RD_W,
                   output W, J, MinCost, MatchCount, Valid, RD_J);
endinterface

// File: rtl/jam_sjt_gen.sv
// rtl/jam_sjt_gen.sv - Steinhaus-Johnson-Trotter permutation generator (one swap per step)
module jam_sjt_gen #(
   parameter int N  = 8,
   parameter int IW = 3
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            init,
   input  logic            step,
   output logic [N*IW-1:0] perm_flat,
   output logic            last
);

   logic [IW-1:0] perm    [N];
   logic          dirs    [N];   // 1 = element points towards the higher worker index
   logic          mobile  [N];
   logic [IW-1:0] perm_nx [N];
   logic          dirs_nx [N];
   logic          found;
   logic [IW-1:0] mob_val;
   logic [IW-1:0] mob_pos;
   logic [IW-1:0] nb_pos;

   always_comb begin
      for (int p = 0; p < N; p++) mobile[p] = 1'b0;
      for (int p = 1; p < N; p++) begin
         if (!dirs[p] && perm[p-1] < perm[p]) mobile[p] = 1'b1;
      end
      for (int p = 0; p < N-1; p++) begin
         if (dirs[p] && perm[p+1] < perm[p]) mobile[p] = 1'b1;
      end

      found   = 1'b0;
      mob_val = '0;
      mob_pos = '0;
      for (int p = 0; p < N; p++) begin
         if (mobile[p] && (!found || perm[p] > mob_val)) begin
            found   = 1'b1;
            mob_val = perm[p];
            mob_pos = IW'(p);
         end
      end
      nb_pos = dirs[mob_pos] ? mob_pos + IW'(1) : mob_pos - IW'(1);

      // Directions travel with their elements, then every larger element turns around.
      for (int p = 0; p < N; p++) begin
         perm_nx[p] = perm[p];
         dirs_nx[p] = dirs[p];
      end
      perm_nx[mob_pos] = perm[nb_pos];
      perm_nx[nb_pos]  = perm[mob_pos];
      dirs_nx[mob_pos] = dirs[nb_pos];
      dirs_nx[nb_pos]  = dirs[mob_pos];
      for (int p = 0; p < N; p++) begin
         if (perm_nx[p] > mob_val) dirs_nx[p] = !dirs_nx[p];
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int p = 0; p < N; p++) begin
            perm[p] <= IW'(p);
            dirs[p] <= 1'b0;
         end
      end else if (init) begin
         for (int p = 0; p < N; p++) begin
            perm[p] <= IW'(p);
            dirs[p] <= 1'b0;
         end
      end else if (step && found) begin
         perm <= perm_nx;
         dirs <= dirs_nx;
      end
   end

   always_comb begin
      perm_flat = '0;
      for (int p = 0; p < N; p++) perm_flat[p*IW +: IW] = perm[p];
   end

   assign last = !found;

endmodule

// File: rtl/jam_perm_solver.sv
// rtl/jam_perm_solver.sv - exhaustive N x N job-assignment solver with partial-sum pruning
module jam_perm_solver
   import jam_pkg::*;
#(
   parameter int N   = 8,
   parameter int IW  = 3,
   parameter int CW  = 7,
   parameter int SW  = 10,
   parameter int MCW = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   jam_perm_solver_if.slave bus
);

   if (N < MIN_N || N > MAX_N || IW < bits_for(longint'(N - 1)) ||
       SW < bits_for(longint'(N) * ((longint'(1) << CW) - 1)) ||
       MCW < bits_for(fact(N))) begin : g_param_check
      $error("jam_perm_solver: parameter set out of range");
   end

   state_t          state, state_nx;
   logic [IW-1:0]   w_r;
   logic [SW-1:0]   acc, acc_next, min_r, min_cost_r;
   logic [MCW-1:0]  cnt_r, match_r;
   logic            valid_r;
   logic [IW-1:0]   best     [N];
   logic [IW-1:0]   perm_arr [N];
   logic [N*IW-1:0] perm_flat;
   logic            sjt_init, sjt_step, sjt_last;
   logic            w_last, prune;

   jam_sjt_gen #(.N(N), .IW(IW)) u_sjt (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .init      (sjt_init),
      .step      (sjt_step),
      .perm_flat (perm_flat),
      .last      (sjt_last)
   );

   always_comb begin
      for (int p = 0; p < N; p++) perm_arr[p] = perm_flat[p*IW +: IW];
   end

   assign acc_next = acc + SW'(bus.Cost);
   assign w_last   = (w_r == IW'(N - 1));
   // Strict compare: a partial sum equal to the best so far may still tie.
   assign prune    = !w_last && (acc_next > min_r);

   always_comb begin
      state_nx = state;
      sjt_init = 1'b0;
      sjt_step = 1'b0;
      case (state)
         IDLE:    if (bus.START) state_nx = INIT;
         INIT:    begin sjt_init = 1'b1; state_nx = EVAL; end
         EVAL:    if (w_last) state_nx = CMP; else if (prune) state_nx = STEP;
         CMP:     state_nx = STEP;
         STEP:    begin sjt_step = 1'b1; state_nx = sjt_last ? DONE : EVAL; end
         DONE:    if (bus.START) state_nx = INIT;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         w_r        <= '0;
         acc        <= '0;
         min_r      <= '1;
         cnt_r      <= '0;
         min_cost_r <= '0;
         match_r    <= '0;
         valid_r    <= 1'b0;
         for (int p = 0; p < N; p++) best[p] <= IW'(p);
      end else begin
         case (state)
            INIT: begin
               w_r     <= '0;
               acc     <= '0;
               min_r   <= '1;
               cnt_r   <= '0;
               valid_r <= 1'b0;
            end
            EVAL: begin
               if (w_last) begin
                  acc <= acc_next;
                  w_r <= '0;
               end else if (prune) begin
                  acc <= '0;
                  w_r <= '0;
               end else begin
                  acc <= acc_next;
                  w_r <= w_r + IW'(1);
               end
            end
            CMP: begin
               if (acc < min_r) begin
                  min_r <= acc;
                  cnt_r <= MCW'(1);
                  best  <= perm_arr;
               end else if (acc == min_r) begin
                  cnt_r <= cnt_r + MCW'(1);
               end
               acc <= '0;
            end
            DONE: begin
               min_cost_r <= min_r;
               match_r    <= cnt_r;
               valid_r    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.W          = w_r;
   assign bus.J          = perm_arr[w_r];
   assign bus.MinCost    = min_cost_r;
   assign bus.MatchCount = match_r;
   assign bus.Valid      = valid_r;
   assign bus.RD_J       = best[bus.RD_W];

endmodule

// File: tb/tb_jam_perm_solver.sv
// tb/tb_jam_perm_solver.sv - directed self-checking bench for jam_perm_solver at N=2, 4 and 6
module tb_jam_perm_solver;

   logic CLK   = 1'b0;
   logic RST_N = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   mode6  = 0;
   int   cyc;
   logic first_valid = 1'b0;

   always #5 CLK = ~CLK;

   jam_perm_solver_if #(.IW(1), .CW(7), .SW(10), .MCW(16)) if2 ();
   jam_perm_solver_if #(.IW(2), .CW(7), .SW(10), .MCW(16)) if4 ();
   jam_perm_solver_if #(.IW(3), .CW(7), .SW(10), .MCW(10)) if6 ();

   jam_perm_solver #(.N(2), .IW(1), .CW(7), .SW(10), .MCW(16)) u2 (.CLK(CLK), .RST_N(RST_N), .bus(if2));
   jam_perm_solver #(.N(4), .IW(2), .CW(7), .SW(10), .MCW(16)) u4 (.CLK(CLK), .RST_N(RST_N), .bus(if4));
   jam_perm_solver #(.N(6), .IW(3), .CW(7), .SW(10), .MCW(10)) u6 (.CLK(CLK), .RST_N(RST_N), .bus(if6));

   always_comb if2.Cost = (if2.W == if2.J) ? 7'd1 : 7'd9;
   always_comb if4.Cost = 7'd5;
   always_comb begin
      case (mode6)
         0:       if6.Cost = (if6.W == if6.J) ? 7'd0 : 7'd10;
         1:       if6.Cost = 7'(if6.J);
         default: if6.Cost = (int'(if6.W) + int'(if6.J) == 5) ? 7'd1 : 7'd4;
      endcase
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_start(input int which, input logic v);
      case (which)
         2:       if2.START = v;
         4:       if4.START = v;
         default: if6.START = v;
      endcase
   endtask

   function automatic logic get_valid(input int which);
      case (which)
         2:       return if2.Valid;
         4:       return if4.Valid;
         default: return if6.Valid;
      endcase
   endfunction

   // Pulses START, then counts edges until Valid; poke_at re-pulses START mid-run.
   task automatic run(input int which, input int poke_at, output int cycles);
      logic v;
      cycles = 0;
      @(negedge CLK);
      set_start(which, 1'b1);
      @(posedge CLK);
      #1;
      set_start(which, 1'b0);
      do begin
         @(posedge CLK);
         #1;
         cycles++;
         if (cycles == 1) first_valid = get_valid(which);
         set_start(which, cycles == poke_at);
         v = get_valid(which);
      end while (!v && cycles < 20000);
      set_start(which, 1'b0);
      if (!v) check_eq("timeout", v, 1);
   endtask

   initial begin
      if2.START = 1'b0; if4.START = 1'b0; if6.START = 1'b0;
      if2.RD_W = '0;    if4.RD_W = '0;    if6.RD_W = '0;

      repeat (2) @(posedge CLK);
      #1;
      check_eq("rst_w",     if2.W, 0);
      check_eq("rst_min",   if2.MinCost, 0);
      check_eq("rst_cnt",   if2.MatchCount, 0);
      check_eq("rst_valid", if2.Valid, 0);
      check_eq("rst6_w",     if6.W, 0);
      check_eq("rst6_valid", if6.Valid, 0);
      @(negedge CLK);
      RST_N = 1'b1;

      run(2, -1, cyc);
      check_eq("n2_cycles", cyc, 8);
      check_eq("n2_min",    if2.MinCost, 2);
      check_eq("n2_cnt",    if2.MatchCount, 1);
      check_eq("n2_w_idle", if2.W, 0);
      if2.RD_W = 1'b0; #1 check_eq("n2_rdj0", if2.RD_J, 0);
      if2.RD_W = 1'b1; #1 check_eq("n2_rdj1", if2.RD_J, 1);

      run(4, -1, cyc);
      check_eq("n4_cycles", cyc, 24 * 6 + 2);
      check_eq("n4_min",    if4.MinCost, 20);
      check_eq("n4_cnt",    if4.MatchCount, 24);

      // Every assignment costs 0+1+..+5 = 15; START pulsed while in EVAL must be ignored.
      mode6 = 1;
      run(6, 3, cyc);
      check_eq("ramp_cycles", cyc, 720 * 8 + 2);
      check_eq("ramp_min",    if6.MinCost, 15);
      check_eq("ramp_cnt",    if6.MatchCount, 720);
      for (int w = 0; w < 6; w++) begin
         if6.RD_W = 3'(w);
         #1 check_eq("ramp_rdj", if6.RD_J, w);
      end

      mode6 = 0;
      @(negedge CLK);
      if6.START = 1'b1;
      @(posedge CLK);
      #1 if6.START = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RST_N = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
      #1;
      check_eq("midrst_w",     if6.W, 0);
      check_eq("midrst_min",   if6.MinCost, 0);
      check_eq("midrst_cnt",   if6.MatchCount, 0);
      check_eq("midrst_valid", if6.Valid, 0);

      // Identity costs 0 and comes first, so every other permutation prunes at its first misplaced worker.
      run(6, -1, cyc);
      check_eq("diag_cycles", cyc, 1596);
      check_eq("diag_pruned", cyc < 720 * 8 + 2, 1);
      check_eq("diag_min",    if6.MinCost, 0);
      check_eq("diag_cnt",    if6.MatchCount, 1);
      for (int w = 0; w < 6; w++) begin
         if6.RD_W = 3'(w);
         #1 check_eq("diag_rdj", if6.RD_J, w);
      end

      mode6 = 2;
      run(6, -1, cyc);
      check_eq("anti_valid_drop", first_valid, 0);
      check_eq("anti_min",        if6.MinCost, 6);
      check_eq("anti_cnt",        if6.MatchCount, 1);
      for (int w = 0; w < 6; w++) begin
         if6.RD_W = 3'(w);
         #1 check_eq("anti_rdj", if6.RD_J, 5 - w);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
